// File: rtl/por_reset_seq.sv
// por_reset_seq: power-on / external / software / watchdog reset sequencer.
// Holds all reset domains asserted for one stage, then releases them one
// at a time (bit 0 first), one stage apart, and reports the last reset cause.
module por_reset_seq #(
    parameter int N_DOMAINS       = 3,
    parameter int STAGE_CYCLES    = 10000,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int WDT_CYCLES      = 12000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ext_rst_n,
    input  logic                 sw_rst_req,
    input  logic                 wdt_en,
    input  logic                 wdt_kick,
    output logic [N_DOMAINS-1:0] rst_out,
    output logic                 ready,
    output logic [1:0]           cause
);
    localparam int CNT_W = $clog2(STAGE_CYCLES);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WDT_W = $clog2(WDT_CYCLES);

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WDT_W-1:0] WDT_LAST   = WDT_W'(WDT_CYCLES - 1);
    localparam logic [2:0]       K_LAST     = 3'(N_DOMAINS - 1);

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;
    localparam logic [1:0] CAUSE_WDT = 2'b11;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_k;
    logic [N_DOMAINS-1:0] r_rst_out;
    logic                 r_ready;
    logic [1:0]           r_cause;

    state_t               w_state_next;
    logic [CNT_W-1:0]     w_cnt_next;
    logic [2:0]           w_k_next;
    logic [N_DOMAINS-1:0] w_rst_out_next;
    logic                 w_ready_next;
    logic [1:0]           w_cause_next;

    logic                 r_sync1;
    logic                 r_sync2;
    logic [DEB_W-1:0]     r_deb_cnt;
    logic [WDT_W-1:0]     r_wdt_cnt;

    logic                 w_ext_trig;
    logic                 w_wdt_trig;
    logic                 w_trig;
    logic                 w_stage_done;
    logic [2:0]           w_rel_idx;
    logic [N_DOMAINS-1:0] w_rel_mask;

    // Two-flop synchroniser for the asynchronous reset button (idles high).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ext_rst_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive synced-low samples, saturating; any high sample restarts.
    always_ff @(posedge clk) begin
        if (rst || r_sync2) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != DEB_LAST) begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

    // The current low sample plus DEBOUNCE_CYCLES-1 earlier ones qualify the button.
    assign w_ext_trig = !r_sync2 && (r_deb_cnt == DEB_LAST);

    // Watchdog only runs while the system is up and enabled; kicks restart it.
    always_ff @(posedge clk) begin
        if (rst || w_trig || (r_state != ST_RUN) || !wdt_en || wdt_kick) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
        end
    end

    assign w_wdt_trig   = (r_state == ST_RUN) && wdt_en && (r_wdt_cnt == WDT_LAST);
    assign w_trig       = w_ext_trig || w_wdt_trig || sw_rst_req;
    assign w_stage_done = (r_cnt == STAGE_LAST);

    // Index of the domain released at the end of the current stage.
    assign w_rel_idx = (r_state == ST_ASSERT) ? 3'd0 : (r_k + 3'd1);

    for (genvar gi = 0; gi < N_DOMAINS; gi++) begin : g_rel_mask
        assign w_rel_mask[gi] = (w_rel_idx == 3'(gi));
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ASSERT;
            r_cnt     <= '0;
            r_k       <= 3'd0;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_cause   <= CAUSE_POR;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_k       <= w_k_next;
            r_rst_out <= w_rst_out_next;
            r_ready   <= w_ready_next;
            r_cause   <= w_cause_next;
        end
    end

    // Next-state: triggers restart everything; otherwise step through stages.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_k_next       = r_k;
        w_rst_out_next = r_rst_out;
        w_ready_next   = r_ready;
        w_cause_next   = r_cause;

        if (w_trig) begin
            w_state_next   = ST_ASSERT;
            w_cnt_next     = '0;
            w_k_next       = 3'd0;
            w_rst_out_next = '1;
            w_ready_next   = 1'b0;
            if (w_ext_trig) begin
                w_cause_next = CAUSE_EXT;
            end else if (w_wdt_trig) begin
                w_cause_next = CAUSE_WDT;
            end else begin
                w_cause_next = CAUSE_SW;
            end
        end else begin
            case (r_state)
                ST_ASSERT, ST_RELEASE: begin
                    if (w_stage_done) begin
                        w_cnt_next     = '0;
                        w_k_next       = w_rel_idx;
                        w_rst_out_next = r_rst_out & ~w_rel_mask;
                        if (w_rel_idx == K_LAST) begin
                            w_state_next = ST_RUN;
                            w_ready_next = 1'b1;
                        end else begin
                            w_state_next = ST_RELEASE;
                        end
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign ready   = r_ready;
    assign cause   = r_cause;

endmodule

// File: tb/tb_por_reset_seq.sv
// Bench for por_reset_seq: expected output snapshots are queued with the
// cycle they are due, then popped and compared as the run reaches them.
module tb_por_reset_seq;
    logic       clk;
    logic       rst;
    logic       ext_rst_n;
    logic       sw_rst_req;
    logic       wdt_en;
    logic       wdt_kick;
    logic [2:0] rst_out;
    logic       ready;
    logic [1:0] cause;

    por_reset_seq #(
        .N_DOMAINS      (3),
        .STAGE_CYCLES   (8),
        .DEBOUNCE_CYCLES(4),
        .WDT_CYCLES     (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_rst_n (ext_rst_n),
        .sw_rst_req(sw_rst_req),
        .wdt_en    (wdt_en),
        .wdt_kick  (wdt_kick),
        .rst_out   (rst_out),
        .ready     (ready),
        .cause     (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         at;
        logic [5:0] v;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Queue an expected {rst_out, ready, cause} due dc cycles from now.
    task automatic push(input int dc, input logic [2:0] ro, input logic rdy,
                        input logic [1:0] c, input string tag);
        exp_t x;
        x.at  = cyc + dc;
        x.v   = {ro, rdy, c};
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        push(1, 3'b111, 1'b0, 2'b00, "rst_hold1");
        push(3, 3'b111, 1'b0, 2'b00, "rst_hold3");
        push(4, 3'b111, 1'b0, 2'b00, "por_c1");
        push(10, 3'b111, 1'b0, 2'b00, "por_c7");
        push(11, 3'b110, 1'b0, 2'b00, "por_c8");
        push(18, 3'b110, 1'b0, 2'b00, "por_c15");
        push(19, 3'b100, 1'b0, 2'b00, "por_c16");
        push(26, 3'b100, 1'b0, 2'b00, "por_c23");
        push(27, 3'b000, 1'b1, 2'b00, "por_c24");
        for (int i = 1; i <= 27; i++) begin
            tick();
            if (i == 3) rst = 1'b0;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if ({rst_out, ready, cause} !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b_%b_%b want=%b", e.tag, cyc, rst_out, ready, cause, e.v);
                end else $display("ok %s cyc=%0d rst_out=%b ready=%b cause=%b", e.tag, cyc, rst_out, ready, cause);
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL reset_leftover got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_sw_run();
        push(1, 3'b000, 1'b1, 2'b00, "sw_before");
        push(2, 3'b111, 1'b0, 2'b10, "sw_assert");
        push(9, 3'b111, 1'b0, 2'b10, "sw_c7");
        push(10, 3'b110, 1'b0, 2'b10, "sw_c8");
        push(18, 3'b100, 1'b0, 2'b10, "sw_c16");
        push(26, 3'b000, 1'b1, 2'b10, "sw_c24");
        for (int i = 1; i <= 26; i++) begin
            tick();
            sw_rst_req = (i == 1);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if ({rst_out, ready, cause} !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b_%b_%b want=%b", e.tag, cyc, rst_out, ready, cause, e.v);
                end else $display("ok %s cyc=%0d rst_out=%b ready=%b cause=%b", e.tag, cyc, rst_out, ready, cause);
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sw_leftover got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_ext_glitch();
        push(12, 3'b000, 1'b1, 2'b10, "ext_glitch_ignored");
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) ext_rst_n = 1'b0;
            if (i == 4) ext_rst_n = 1'b1;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if ({rst_out, ready, cause} !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b_%b_%b want=%b", e.tag, cyc, rst_out, ready, cause, e.v);
                end else $display("ok %s cyc=%0d rst_out=%b ready=%b cause=%b", e.tag, cyc, rst_out, ready, cause);
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL glitch_leftover got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_ext_long();
        push(6, 3'b000, 1'b1, 2'b10, "ext_not_yet");
        push(7, 3'b111, 1'b0, 2'b01, "ext_assert");
        push(12, 3'b111, 1'b0, 2'b01, "ext_held");
        push(20, 3'b111, 1'b0, 2'b01, "ext_rel_c7");
        push(21, 3'b110, 1'b0, 2'b01, "ext_rel_c8");
        push(37, 3'b000, 1'b1, 2'b01, "ext_rel_c24");
        for (int i = 1; i <= 37; i++) begin
            tick();
            if (i == 1) ext_rst_n = 1'b0;
            if (i == 11) ext_rst_n = 1'b1;
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if ({rst_out, ready, cause} !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b_%b_%b want=%b", e.tag, cyc, rst_out, ready, cause, e.v);
                end else $display("ok %s cyc=%0d rst_out=%b ready=%b cause=%b", e.tag, cyc, rst_out, ready, cause);
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL ext_leftover got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_watchdog();
        wdt_en = 1'b1;
        push(19, 3'b000, 1'b1, 2'b01, "wdt_c19");
        push(20, 3'b111, 1'b0, 2'b11, "wdt_fire");
        for (int i = 1; i <= 20; i++) begin
            tick();
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if ({rst_out, ready, cause} !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b_%b_%b want=%b", e.tag, cyc, rst_out, ready, cause, e.v);
                end else $display("ok %s cyc=%0d rst_out=%b ready=%b cause=%b", e.tag, cyc, rst_out, ready, cause);
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL wdt_leftover got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_kick();
        push(24, 3'b000, 1'b1, 2'b11, "kick_run");
        push(84, 3'b000, 1'b1, 2'b11, "kick_still_run");
        for (int i = 1; i <= 84; i++) begin
            tick();
            wdt_kick = (i % 15 == 0);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if ({rst_out, ready, cause} !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b_%b_%b want=%b", e.tag, cyc, rst_out, ready, cause, e.v);
                end else $display("ok %s cyc=%0d rst_out=%b ready=%b cause=%b", e.tag, cyc, rst_out, ready, cause);
            end
        end
        wdt_kick = 1'b0;
        wdt_en   = 1'b0;
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL kick_leftover got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_sw_during_seq();
        rst = 1'b1;
        push(1, 3'b111, 1'b0, 2'b00, "mid_rst");
        push(12, 3'b110, 1'b0, 2'b00, "mid_c11");
        push(13, 3'b111, 1'b0, 2'b10, "mid_reassert");
        push(20, 3'b111, 1'b0, 2'b10, "mid_c7");
        push(21, 3'b110, 1'b0, 2'b10, "mid_c8");
        push(29, 3'b100, 1'b0, 2'b10, "mid_c16");
        push(37, 3'b000, 1'b1, 2'b10, "mid_c24");
        for (int i = 1; i <= 37; i++) begin
            tick();
            if (i == 1) rst = 1'b0;
            sw_rst_req = (i == 12);
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if ({rst_out, ready, cause} !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b_%b_%b want=%b", e.tag, cyc, rst_out, ready, cause, e.v);
                end else $display("ok %s cyc=%0d rst_out=%b ready=%b cause=%b", e.tag, cyc, rst_out, ready, cause);
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL mid_leftover got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_simultaneous();
        wdt_en = 1'b1;
        push(19, 3'b000, 1'b1, 2'b10, "sim_before");
        push(20, 3'b111, 1'b0, 2'b11, "sim_wdt_wins");
        push(22, 3'b111, 1'b0, 2'b00, "sim_rst_wins");
        push(23, 3'b111, 1'b0, 2'b00, "sim_after_rst");
        push(30, 3'b110, 1'b0, 2'b00, "sim_c8");
        push(46, 3'b000, 1'b1, 2'b00, "sim_c24");
        for (int i = 1; i <= 46; i++) begin
            tick();
            sw_rst_req = (i == 19) || (i == 21);
            if (i == 21) begin rst = 1'b1; ext_rst_n = 1'b0; wdt_en = 1'b0; end
            if (i == 22) begin rst = 1'b0; ext_rst_n = 1'b1; end
            while (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                total++;
                if ({rst_out, ready, cause} !== e.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%b_%b_%b want=%b", e.tag, cyc, rst_out, ready, cause, e.v);
                end else $display("ok %s cyc=%0d rst_out=%b ready=%b cause=%b", e.tag, cyc, rst_out, ready, cause);
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sim_leftover got=%0d want=0", sb.size()); sb.delete(); end
    endtask

    initial begin
        rst        = 1'b1;
        ext_rst_n  = 1'b1;
        sw_rst_req = 1'b0;
        wdt_en     = 1'b0;
        wdt_kick   = 1'b0;
        test_reset();
        test_sw_run();
        test_ext_glitch();
        test_ext_long();
        test_watchdog();
        test_kick();
        test_sw_during_seq();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/por_reset_seq.md
POR_RESET_SEQ -- requirements
Module: por_reset_seq

Interface
REQ-001 SHALL have parameter N_DOMAINS, default 3, number of independently released reset domains (1..8).
REQ-002 SHALL have parameter STAGE_CYCLES, default 10000, clk cycles between successive release steps (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive synced-low cycles to qualify external reset (>=1).
REQ-004 SHALL have parameter WDT_CYCLES, default 12000000, watchdog timeout in clk cycles (>=2).
REQ-005 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ext_rst_n  input  1  asynchronous active-low reset button.
REQ-008 SHALL have port sw_rst_req  input  1  single-cycle software reset request.
REQ-009 SHALL have port wdt_en  input  1  watchdog enable.
REQ-010 SHALL have port wdt_kick  input  1  watchdog restart pulse.
REQ-011 SHALL have port rst_out  output  N_DOMAINS  active-high per-domain resets, bit 0 released first.
REQ-012 SHALL have port ready  output  1  high when all domains released.
REQ-013 SHALL have port cause  output  2  last reset cause: 00 POR, 01 external, 10 software, 11 watchdog.

Function
REQ-014 SHALL synchronise ext_rst_n through two flops before use.
REQ-015 SHALL raise ext_trig while synced ext_rst_n has been low for >= DEBOUNCE_CYCLES consecutive cycles; any high sample clears the debounce counter.
REQ-016 SHALL implement states ASSERT, RELEASE, RUN with stage index k (0..N_DOMAINS-1) and stage counter 0..STAGE_CYCLES-1.
REQ-017 ASSERT: rst_out all ones, ready 0; counter increments; at STAGE_CYCLES-1 -> RELEASE, k=0, counter 0.
REQ-018 RELEASE: on the transition into RELEASE with index k, rst_out[k] SHALL go low (registered); counter restarts; at STAGE_CYCLES-1 k increments and the next bit releases.
REQ-019 Releasing bit N_DOMAINS-1 SHALL enter RUN with ready=1 in the same cycle; rst_out[0] low at cycle STAGE_CYCLES, rst_out[k] low at (k+1)*STAGE_CYCLES, counted from the first edge with rst=0.
REQ-020 Released bits SHALL stay low until the next trigger; bits never release out of order.
REQ-021 Watchdog counter SHALL count only in RUN with wdt_en=1; cleared by wdt_kick, by wdt_en=0, or outside RUN; reaching WDT_CYCLES-1 raises wdt_trig.
REQ-022 Any trigger (ext_trig, sw_rst_req, wdt_trig) in any state SHALL, next edge: state ASSERT, counter 0, rst_out all ones, ready 0, cause updated.
REQ-023 Simultaneous triggers SHALL set cause by priority external > watchdog > software.
REQ-024 While ext_trig stays high SHALL hold ASSERT with counter at 0; sequence restarts the cycle after it drops.
REQ-025 Trigger during ASSERT/RELEASE SHALL restart the full sequence from counter 0.
REQ-026 cause SHALL be sticky; changes only on a trigger or rst.

Reset
REQ-027 On rst: state ASSERT, counter 0, k 0, rst_out all ones, ready 0, cause 00, sync flops 1, debounce and watchdog counters 0.
REQ-028 rst mid-sequence or in RUN SHALL override all triggers and restart identically to power-up.

Verification (N_DOMAINS=3, STAGE_CYCLES=8, DEBOUNCE_CYCLES=4, WDT_CYCLES=20)
REQ-029 rst 1 for 3 cycles then 0 -> rst_out 111 until cycle 8, 110 at 8, 100 at 16, 000 and ready=1 at 24, cause 00.
REQ-030 In RUN, ext_rst_n low 3 cycles then high -> no reset; low 10 cycles -> rst_out 111 two sync cycles + 4 after falling edge, held until release, sequence restarts, cause 01.
REQ-031 In RUN, sw_rst_req pulse -> rst_out 111, ready 0 next edge, cause 10, release at +8/+16/+24.
REQ-032 wdt_en=1, no kick -> trigger 20 cycles into RUN, cause 11; kick every 15 cycles -> no reset.
REQ-033 sw_rst_req at cycle 12 of initial sequence -> rst_out[0] reasserts, full sequence restarts from counter 0.
REQ-034 sw_rst_req and watchdog timeout same cycle -> cause 11; rst asserted with triggers pending -> cause 00.
